// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic, iterative shift-add multiply and
// restoring divide. Divider present only when ALU_SEQ_DIV_EN is defined.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2:0]         opcode,
   input  logic               mode,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] out_alu,
   output logic               za,
   output logic               zb,
   output logic               eq,
   output logic               gt,
   output logic               lt,
   output logic               err
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

   typedef struct packed {
      logic za;
      logic zb;
      logic eq;
      logic gt;
      logic lt;
   } flags_t;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;

   function automatic flags_t cmp_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      flags_t f;
      f.za = (x == '0);
      f.zb = (y == '0);
      f.eq = (x == y);
      f.gt = (x > y);
      f.lt = (x < y);
      return f;
   endfunction

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] out_alu_q, out_alu_d;
   flags_t             flags_q, flags_d;
   logic               err_q, err_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   // Single-cycle result straight from the ports, registered on the accepting edge.
   logic [WIDTH:0]     sum_w, diff_w;
   logic [WIDTH-1:0]   logic_res;
   logic [2*WIDTH-1:0] single_res;
   logic               single_err;

   assign sum_w  = {1'b0, a} + {1'b0, b};
   assign diff_w = {1'b0, a} - {1'b0, b};

   always_comb begin
      // NOTE: every variable gets a default first so no path through the case infers a latch.
      logic_res  = '0;
      single_res = '0;
      single_err = 1'b0;
      unique case (opcode)
         3'd0: logic_res = a & b;
         3'd1: logic_res = a | b;
         3'd2: logic_res = a ^ b;
         3'd3: logic_res = ~(a & b);
         3'd4: logic_res = ~(a | b);
         3'd5: logic_res = ~(a ^ b);
         3'd6: logic_res = ~a;
         3'd7: logic_res = a << b[CW-1:0];
      endcase
      if (mode) begin
         single_res = {{WIDTH{1'b0}}, logic_res};
      end else begin
         unique case (opcode)
            OP_ADD:  single_res = {{(WIDTH-1){1'b0}}, sum_w};
            OP_SUB:  single_res = {{(WIDTH-1){1'b0}}, diff_w};
            default: single_err = 1'b1;
         endcase
      end
   end

   // acc holds {partial product, remaining multiplier} for MUL.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, step_next;
   logic               step_err;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
   // acc holds {remainder, dividend/quotient}; B=0 naturally yields all-ones and rem=A.
   logic               is_div_q, is_div_d;
   logic [WIDTH:0]     div_shift, div_sub;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;

   assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_ge    = (div_shift >= {1'b0, b_q});
   assign div_sub   = div_shift - {1'b0, b_q};
   assign div_next  = {(div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ge};
   assign step_next = is_div_q ? div_next : mul_next;
   assign step_err  = is_div_q & (b_q == '0);
`else
   assign step_next = mul_next;
   assign step_err  = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      out_alu_d = out_alu_q;
      flags_d   = flags_q;
      err_d     = err_q;
      done_d    = 1'b0;
`ifdef ALU_SEQ_DIV_EN
      is_div_d  = is_div_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d = a;
               b_d = b;
               if (!mode && opcode == OP_MUL) begin
                  acc_d   = {{WIDTH{1'b0}}, b};
                  cnt_d   = CW'(WIDTH - 1);
                  state_d = S_ITER;
`ifdef ALU_SEQ_DIV_EN
                  is_div_d = 1'b0;
               end else if (!mode && opcode == OP_DIV) begin
                  acc_d    = {{WIDTH{1'b0}}, a};
                  cnt_d    = CW'(WIDTH - 1);
                  state_d  = S_ITER;
                  is_div_d = 1'b1;
`endif
               end else begin
                  out_alu_d = single_res;
                  err_d     = single_err;
                  flags_d   = cmp_flags(a, b);
                  done_d    = 1'b1;
                  state_d   = S_FIN;
               end
            end
         end
         S_ITER: begin
            acc_d = step_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               out_alu_d = step_next;
               err_d     = step_err;
               flags_d   = cmp_flags(a_q, b_q);
               done_d    = 1'b1;
               state_d   = S_FIN;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: datapath registers are reset too, so a mid-operation reset leaves no stale result.
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         out_alu_q <= '0;
         flags_q   <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         is_div_q  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         out_alu_q <= out_alu_d;
         flags_q   <= flags_d;
         err_q     <= err_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
`ifdef ALU_SEQ_DIV_EN
         is_div_q  <= is_div_d;
`endif
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign out_alu = out_alu_q;
   assign err     = err_q;
   assign za      = flags_q.za;
   assign zb      = flags_q.zb;
   assign eq      = flags_q.eq;
   assign gt      = flags_q.gt;
   assign lt      = flags_q.lt;

endmodule
